// File: rtl/pong_pkg.sv
// Shared types and codes for the Pong match sequencer and the score/display logic.
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StPoint = 3'd4,
    StOver  = 3'd5
  } pong_state_e;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;
  localparam logic [1:0] WINNER_DRAW  = 2'b11;

  // Bit 0 flags the left player, bit 1 the right; both set means a draw.
  function automatic logic [1:0] winner_code(input logic left_won, input logic right_won);
    return {right_won, left_won};
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame-tick down-counter used for the serve delay and the post-point hold.
module pong_frame_timer #(
  parameter int unsigned TmrW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [TmrW-1:0] load_val_i,
  input  logic            frame_tick_i,
  output logic            zero_o
);

  localparam logic [TmrW-1:0] TmrOne = TmrW'(1);

  logic [TmrW-1:0] count_q, count_d;

  // A load wins over a coincident tick so a newly entered state gets its full count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (frame_tick_i && (count_q != '0)) begin
      count_d = count_q - TmrOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve, play, pause, point hold and game-over with registered outputs.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WinScore   = 7,
  parameter int unsigned ScoreW     = 4,
  parameter int unsigned ServeDelay = 60,
  parameter int unsigned PointHold  = 90,
  parameter int unsigned TmrW       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick_i,
  input  logic              start_btn_i,
  input  logic              pause_btn_i,
  input  logic              miss_left_i,
  input  logic              miss_right_i,
  output logic [2:0]        state_o,
  output logic              ball_en_o,
  output logic              ball_rst_o,
  output logic              serve_dir_o,
  output logic [ScoreW-1:0] score_l_o,
  output logic [ScoreW-1:0] score_r_o,
  output logic              game_over_o,
  output logic [1:0]        winner_o
);

  localparam logic [ScoreW-1:0] WinVal    = ScoreW'(WinScore);
  localparam logic [ScoreW-1:0] ScoreOne  = ScoreW'(1);
  localparam logic [TmrW-1:0]   ServeVal  = TmrW'(ServeDelay);
  localparam logic [TmrW-1:0]   PointVal  = TmrW'(PointHold);

  pong_state_e       state_q, state_d;
  logic              start_q, pause_q;
  logic [ScoreW-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic              serve_dir_q, serve_dir_d;
  logic [1:0]        winner_q, winner_d;
  logic              ball_en_q, ball_en_d;
  logic              ball_rst_q, ball_rst_d;
  logic              game_over_q, game_over_d;

  logic              start_edge, pause_edge, any_miss;
  logic              tmr_load, tmr_zero;
  logic [TmrW-1:0]   tmr_val;

  assign start_edge = start_btn_i & ~start_q;
  assign pause_edge = pause_btn_i & ~pause_q;
  assign any_miss   = miss_left_i | miss_right_i;

  pong_frame_timer #(
    .TmrW (TmrW)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (tmr_load),
    .load_val_i   (tmr_val),
    .frame_tick_i (frame_tick_i),
    .zero_o       (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    tmr_load    = 1'b0;
    tmr_val     = ServeVal;

    unique case (state_q)
      StIdle, StOver: begin
        if (start_edge) begin
          state_d     = StServe;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = 1'b0;
          winner_d    = WINNER_NONE;
          tmr_load    = 1'b1;
        end
      end
      StServe: begin
        if (tmr_zero) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (any_miss) begin
          state_d  = StPoint;
          tmr_load = 1'b1;
          tmr_val  = PointVal;
          if (miss_left_i && (score_r_q != WinVal)) begin
            score_r_d = score_r_q + ScoreOne;
          end
          if (miss_right_i && (score_l_q != WinVal)) begin
            score_l_d = score_l_q + ScoreOne;
          end
          // Serve goes toward the player who missed; a double miss keeps the old direction.
          if (miss_left_i != miss_right_i) begin
            serve_dir_d = miss_right_i;
          end
        end else if (pause_edge) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (pause_edge) begin
          state_d = StPlay;
        end
      end
      StPoint: begin
        if (tmr_zero) begin
          if ((score_l_q == WinVal) || (score_r_q == WinVal)) begin
            state_d  = StOver;
            winner_d = winner_code(score_l_q == WinVal, score_r_q == WinVal);
          end else begin
            state_d  = StServe;
            tmr_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ball_en_d   = (state_d == StPlay);
    ball_rst_d  = (state_d != StPlay) && (state_d != StPause);
    game_over_d = (state_d == StOver);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b1;
      pause_q     <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= WINNER_NONE;
      ball_en_q   <= 1'b0;
      ball_rst_q  <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_btn_i;
      pause_q     <= pause_btn_i;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_en_q   <= ball_en_d;
      ball_rst_q  <= ball_rst_d;
      game_over_q <= game_over_d;
    end
  end

  assign state_o     = state_q;
  assign ball_en_o   = ball_en_q;
  assign ball_rst_o  = ball_rst_q;
  assign serve_dir_o = serve_dir_q;
  assign score_l_o   = score_l_q;
  assign score_r_o   = score_r_q;
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a short serve delay, point hold and winning score.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, start_btn, pause_btn, miss_left, miss_right;
  logic [2:0] state;
  logic       ball_en, ball_rst, serve_dir, game_over;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_err = 0;

  pong_game_ctrl #(
    .WinScore   (2),
    .ScoreW     (4),
    .ServeDelay (3),
    .PointHold  (2),
    .TmrW       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick_i (frame_tick),
    .start_btn_i  (start_btn),
    .pause_btn_i  (pause_btn),
    .miss_left_i  (miss_left),
    .miss_right_i (miss_right),
    .state_o      (state),
    .ball_en_o    (ball_en),
    .ball_rst_o   (ball_rst),
    .serve_dir_o  (serve_dir),
    .score_l_o    (score_l),
    .score_r_o    (score_r),
    .game_over_o  (game_over),
    .winner_o     (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pulses, then sample 1 time unit after the edge.
  task automatic step(input logic ft, input logic ml, input logic mr);
    frame_tick = ft;
    miss_left  = ml;
    miss_right = mr;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0; start_btn = 1'b1; pause_btn = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_ball_en", 8'(ball_en), 8'd0);
    chk("rst_ball_rst", 8'(ball_rst), 8'd1);
    chk("rst_score_l", 8'(score_l), 8'd0);
    chk("rst_score_r", 8'(score_r), 8'd0);
    chk("rst_winner", 8'(winner), 8'd0);
    chk("rst_game_over", 8'(game_over), 8'd0);
    chk("rst_serve_dir", 8'(serve_dir), 8'd0);

    // Start held through reset gives no edge.
    reset = 1'b0;
    step(0, 0, 0);
    chk("held_start_idle", 8'(state), 8'd0);
    start_btn = 1'b0;
    step(0, 0, 0);
    chk("released_idle", 8'(state), 8'd0);
    start_btn = 1'b1;
    step(0, 0, 0);
    chk("start_serve", 8'(state), 8'd1);
    chk("serve_ball_rst", 8'(ball_rst), 8'd1);
    chk("serve_score_l", 8'(score_l), 8'd0);

    // Serve countdown; pause edge and miss ignored while serving.
    pause_btn = 1'b1;
    step(1, 0, 1);
    chk("serve_miss_ignored", 8'(score_l), 8'd0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("serve_after_3_ticks", 8'(state), 8'd1);
    step(0, 0, 0);
    chk("play_entry", 8'(state), 8'd2);
    chk("play_ball_en", 8'(ball_en), 8'd1);
    chk("play_ball_rst", 8'(ball_rst), 8'd0);

    // Pause and resume.
    pause_btn = 1'b0;
    step(0, 0, 0);
    chk("play_hold", 8'(state), 8'd2);
    pause_btn = 1'b1;
    step(0, 0, 0);
    chk("pause_entry", 8'(state), 8'd3);
    chk("pause_ball_en", 8'(ball_en), 8'd0);
    chk("pause_ball_rst", 8'(ball_rst), 8'd0);
    step(0, 1, 1);
    chk("pause_miss_state", 8'(state), 8'd3);
    chk("pause_miss_score_l", 8'(score_l), 8'd0);
    chk("pause_miss_score_r", 8'(score_r), 8'd0);
    pause_btn = 1'b0;
    step(0, 0, 0);
    pause_btn = 1'b1;
    step(0, 0, 0);
    chk("resume_play", 8'(state), 8'd2);

    // Double miss with pause edge: both score, miss wins over pause.
    pause_btn = 1'b0;
    step(0, 0, 0);
    pause_btn = 1'b1;
    step(0, 1, 1);
    chk("dbl_miss_state", 8'(state), 8'd4);
    chk("dbl_miss_score_l", 8'(score_l), 8'd1);
    chk("dbl_miss_score_r", 8'(score_r), 8'd1);
    chk("dbl_miss_dir", 8'(serve_dir), 8'd0);
    chk("point_ball_rst", 8'(ball_rst), 8'd1);

    // Point hold; the tick on the exit cycle belongs to POINT.
    step(1, 0, 0);
    step(1, 0, 0);
    chk("point_at_zero", 8'(state), 8'd4);
    step(1, 0, 0);
    chk("point_to_serve", 8'(state), 8'd1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("serve_full_reload", 8'(state), 8'd1);
    step(1, 0, 0);
    chk("serve_zero", 8'(state), 8'd1);
    step(0, 0, 0);
    chk("play_again", 8'(state), 8'd2);

    // Right miss gives left the winning point.
    step(0, 0, 1);
    chk("miss_r_state", 8'(state), 8'd4);
    chk("miss_r_score_l", 8'(score_l), 8'd2);
    chk("miss_r_score_r", 8'(score_r), 8'd1);
    chk("miss_r_dir", 8'(serve_dir), 8'd1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("over_state", 8'(state), 8'd5);
    chk("over_game_over", 8'(game_over), 8'd1);
    chk("over_winner", 8'(winner), 8'd1);
    chk("over_ball_en", 8'(ball_en), 8'd0);
    chk("over_ball_rst", 8'(ball_rst), 8'd1);
    chk("over_score_l", 8'(score_l), 8'd2);

    // Restart from OVER.
    start_btn = 1'b0;
    step(0, 0, 0);
    chk("over_hold", 8'(state), 8'd5);
    start_btn = 1'b1;
    step(0, 0, 0);
    chk("restart_state", 8'(state), 8'd1);
    chk("restart_score_l", 8'(score_l), 8'd0);
    chk("restart_score_r", 8'(score_r), 8'd0);
    chk("restart_winner", 8'(winner), 8'd0);
    chk("restart_game_over", 8'(game_over), 8'd0);
    chk("restart_dir", 8'(serve_dir), 8'd0);

    // Asynchronous reset mid-play.
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("play_before_reset", 8'(state), 8'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 8'(state), 8'd0);
    chk("async_rst_ball_en", 8'(ball_en), 8'd0);
    chk("async_rst_ball_rst", 8'(ball_rst), 8'd1);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
